// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared types, sizes and helpers for the write-back register file
//
// Purpose: common constants and typedefs for wb_regfile and wb_scoreboard,
// plus the saturating increment used by the drop counter.
// Contents:
//   ADRS_W, DATA_W, REG_CNT, DROP_W  default sizes
//   t_RFadrs, t_data                 address and data types
//   sat_inc()                        increment that holds at all-ones
// Configuration macro used by this bundle: WB_REGFILE_BYPASS_EN

package wb_regfile_pkg;

  localparam int ADRS_W  = 4;
  localparam int DATA_W  = 16;
  localparam int REG_CNT = 2 ** ADRS_W;
  localparam int DROP_W  = 8;

  typedef logic [ADRS_W-1:0] t_RFadrs;
  typedef logic [DATA_W-1:0] t_data;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] i_val);
    return (i_val == '1) ? i_val : i_val + 1'b1;
  endfunction

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - per-register pending scoreboard driving operand-valid flags
//
// Purpose: tracks which registers have an issued-but-uncommitted writer.
// Ports:
//   clock, reset                 design clock, synchronous active-high reset
//   i_commit, i_wb_dst           a commit to a non-zero register is happening this cycle
//   i_issue_en, i_issue_dst      decode marks a destination pending
//   i_rd_adrs_a, i_rd_adrs_b     read addresses
//   o_rd_valid_a, o_rd_valid_b   operand is not pending
// Configuration: WB_REGFILE_BYPASS_EN makes a same-cycle commit appear valid.

module wb_scoreboard #(
  parameter int ADRS_W = wb_regfile_pkg::ADRS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_commit,
  input  logic [ADRS_W-1:0] i_wb_dst,
  input  logic              i_issue_en,
  input  logic [ADRS_W-1:0] i_issue_dst,
  input  logic [ADRS_W-1:0] i_rd_adrs_a,
  input  logic [ADRS_W-1:0] i_rd_adrs_b,
  output logic              o_rd_valid_a,
  output logic              o_rd_valid_b
);

  localparam int REG_CNT = 2 ** ADRS_W;

  logic [REG_CNT-1:0] r_pending;
  logic [REG_CNT-1:0] w_pending_nxt;
  logic               w_issue;

  assign w_issue = i_issue_en && (i_issue_dst != '0);

  // Issue is applied after commit so a newer instruction keeps ownership
  // of a register that an older one is retiring in the same cycle.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_commit) w_pending_nxt[i_wb_dst] = 1'b0;
    if (w_issue)  w_pending_nxt[i_issue_dst] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  function automatic logic valid_of(input logic [ADRS_W-1:0] i_adrs);
`ifdef WB_REGFILE_BYPASS_EN
    // i_commit already excludes register 0.
    if (i_commit && (i_adrs == i_wb_dst))
      return !(w_issue && (i_issue_dst == i_adrs));
`endif
    return !r_pending[i_adrs];
  endfunction

  assign o_rd_valid_a = valid_of(i_rd_adrs_a);
  assign o_rd_valid_b = valid_of(i_rd_adrs_b);

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage register file with pending scoreboard and drop counter
//
// Purpose: commits EX-to-WB writes into a flop register file, counts writes
// discarded for invalid data, and serves two combinational read ports.
// Ports:
//   clock, reset                      design clock, synchronous active-high reset
//   wb_wr_en, wb_dst, wb_data, wb_datav  write request from the EX-to-WB register
//   issue_en, issue_dst               decode marks a destination pending
//   rd_adrs_a/b -> rd_data_a/b        combinational read data
//   rd_valid_a/b                      operand not pending
//   drop_cnt                          saturating count of discarded writes
// Configuration: define WB_REGFILE_BYPASS_EN for write-to-read bypass.

module wb_regfile #(
  parameter int ADRS_W = wb_regfile_pkg::ADRS_W,
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_wr_en,
  input  logic [ADRS_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_datav,
  input  logic              issue_en,
  input  logic [ADRS_W-1:0] issue_dst,
  input  logic [ADRS_W-1:0] rd_adrs_a,
  input  logic [ADRS_W-1:0] rd_adrs_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  output logic [7:0]        drop_cnt
);

  import wb_regfile_pkg::*;

  localparam int RF_CNT = 2 ** ADRS_W;

  logic [DATA_W-1:0] r_regs [RF_CNT];
  logic [7:0]        r_drop_cnt;
  logic              w_commit;
  logic              w_drop;

  // Register 0 is never a commit or drop target.
  assign w_commit = wb_wr_en && wb_datav  && (wb_dst != '0);
  assign w_drop   = wb_wr_en && !wb_datav && (wb_dst != '0);

  // Entry 0 is cleared at reset and never written, so it always reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RF_CNT; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[wb_dst] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
  end

  assign drop_cnt = r_drop_cnt;

  function automatic logic [DATA_W-1:0] read_of(input logic [ADRS_W-1:0] i_adrs);
`ifdef WB_REGFILE_BYPASS_EN
    if (w_commit && (i_adrs == wb_dst)) return wb_data;
`endif
    return r_regs[i_adrs];
  endfunction

  assign rd_data_a = read_of(rd_adrs_a);
  assign rd_data_b = read_of(rd_adrs_b);

  wb_scoreboard #(.ADRS_W(ADRS_W)) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .i_commit     (w_commit),
    .i_wb_dst     (wb_dst),
    .i_issue_en   (issue_en),
    .i_issue_dst  (issue_dst),
    .i_rd_adrs_a  (rd_adrs_a),
    .i_rd_adrs_b  (rd_adrs_b),
    .o_rd_valid_a (rd_valid_a),
    .o_rd_valid_b (rd_valid_b)
  );

endmodule
